// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame parameters and
// a 3-input majority helper used by the receiver's optional glitch filter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLOCKS_PER_PULSE = 16;
  localparam int UART_DATA_WIDTH       = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; with UART_RX_MAJORITY_EN defined
// the sample value is a 3-cycle majority vote of the synchronised line.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s,
  output logic rx_sample
);

  logic rx_m;
  logic rx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_q <= rx_m;
    end
  end

  assign rx_s = rx_q;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s one cycle ago, hist[1] two cycles ago
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= 2'b11;
    else       hist <= {hist[0], rx_q};
  end

  assign rx_sample = maj3(rx_q, hist[0], hist[1]);
`else
  assign rx_sample = rx_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop FSM with bit-period counters and shift register.
// Optional 3-sample majority filtering is enabled with UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
  parameter int DATA_WIDTH       = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic rx_s;
  logic rx_sample;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .rx_s      (rx_s),
    .rx_sample (rx_sample)
  );

  uart_state_t           state, state_nx;
  logic [CW-1:0]         c_clocks, c_clocks_nx;
  logic [BW-1:0]         c_bits, c_bits_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx;
  logic                  ferr_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      c_clocks   <= '0;
      c_bits     <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      c_clocks   <= c_clocks_nx;
      c_bits     <= c_bits_nx;
      shreg      <= shreg_nx;
      data_out   <= data_nx;
      data_valid <= valid_nx;
      frame_err  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    c_clocks_nx = c_clocks + CW'(1);
    c_bits_nx   = c_bits;
    shreg_nx    = shreg;
    data_nx     = data_out;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        c_clocks_nx = '0;
        if (!rx_s) begin
          state_nx  = ST_START;
          c_bits_nx = '0;
        end
      end
      ST_START: begin
        // a high line at mid start bit is a glitch: drop back silently
        if (c_clocks == HALF_TC) begin
          c_clocks_nx = '0;
          state_nx    = rx_sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (c_clocks == FULL_TC) begin
          c_clocks_nx = '0;
          shreg_nx    = {rx_sample, shreg[DATA_WIDTH-1:1]};
          c_bits_nx   = c_bits + BW'(1);
          if (c_bits == LAST_BIT) state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        // leave at mid stop bit so a back-to-back start edge is seen in IDLE
        if (c_clocks == FULL_TC) begin
          c_clocks_nx = '0;
          state_nx    = ST_IDLE;
          if (rx_sample) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            ferr_nx  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rx_busy = (state != ST_IDLE);

endmodule
